// File: rtl/instruction_cache_fill_pkg.sv
// Shared instruction cache types: geometry, address layout, write enables, fill FSM states.
// Pure declarations, no logic.
// Imported by the fill handler and the cache arrays.
package instruction_cache_fill_pkg;

  localparam int CACHE_SIZE = 2**13;
  localparam int BLOCK_SIZE = 16;
  localparam int BEATS      = BLOCK_SIZE / 4;
  localparam int OFFSET     = $clog2(BEATS);
  localparam int INDEX      = $clog2(CACHE_SIZE / BLOCK_SIZE);
  // Tag covers every address bit above the index so the fields tile 32 bits exactly
  localparam int TAG_SIZE   = 32 - INDEX - OFFSET - 2;

  typedef logic [31:0] data_word_t;

  typedef struct packed {
    logic data;
    logic valid;
    logic tag;
  } instruction_enable_t;

  typedef struct packed {
    logic [TAG_SIZE-1:0] tag;
    logic [INDEX-1:0]    index;
    logic [OFFSET-1:0]   bank_select;
    logic [1:0]          byte_offset;
  } cache_address_t;

  typedef enum logic [2:0] {
    ST_INVALIDATE,
    ST_IDLE,
    ST_COMPARE,
    ST_REQUEST,
    ST_FILL,
    ST_VALIDATE
  } icache_fill_state_t;

  // First byte of the block containing addr
  function automatic cache_address_t block_base(input cache_address_t addr);
    cache_address_t b;
    b             = addr;
    b.bank_select = '0;
    b.byte_offset = '0;
    return b;
  endfunction

endpackage

// File: rtl/instruction_cache_fill.sv
// Instruction cache miss handler: clears valid bits, fetches missing blocks, writes data/tag/valid.
// Latency: miss to fill_done_o = 2 + ack wait + beat arrival + 1 cycles; invalidate takes 2**INDEX cycles.
// Backpressure: stall_o holds the fetch unit; mem_request_o is held until mem_ack_i, beats are accepted whenever mem_valid_i.
module instruction_cache_fill
  import instruction_cache_fill_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                fetch_i,
  input  logic [31:0]         fetch_address_i,
  input  logic                hit_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                fill_done_o,
  output logic                mem_request_o,
  output logic [31:0]         mem_address_o,
  input  logic                mem_ack_i,
  input  logic                mem_valid_i,
  input  data_word_t          mem_data_i,
  output logic [31:0]         write_address_o,
  output instruction_enable_t write_o,
  output data_word_t          instruction_o,
  output logic                valid_o
);

  icache_fill_state_t  state_q, state_d;
  logic [INDEX-1:0]    index_q;
  logic [OFFSET-1:0]   beat_q;
  logic                flush_pending_q;
  cache_address_t      fetch_addr_q;
  cache_address_t      base;
  cache_address_t      beat_addr;
  logic                last_index;
  logic                last_beat;
  logic                flush_any;

  // Next values of the registered outputs
  logic                fill_done_d;
  logic                mem_request_d;
  logic [31:0]         mem_address_d;
  logic [31:0]         write_address_d;
  instruction_enable_t write_d;
  data_word_t          instruction_d;
  logic                valid_d;

  assign base       = block_base(fetch_addr_q);
  assign last_index = (index_q == '1);
  assign last_beat  = (beat_q == OFFSET'(BEATS - 1));
  assign flush_any  = flush_i | flush_pending_q;

  always_comb begin
    beat_addr             = base;
    beat_addr.bank_select = beat_q;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_INVALIDATE;
    else          state_q <= state_d;
  end

  // Next-state decode; a hit with a flush outstanding goes straight to invalidation
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INVALIDATE: if (!flush_i && last_index) state_d = ST_IDLE;
      ST_IDLE: begin
        if (fetch_i)        state_d = ST_COMPARE;
        else if (flush_any) state_d = ST_INVALIDATE;
      end
      ST_COMPARE: begin
        if (!hit_i)         state_d = ST_REQUEST;
        else if (flush_any) state_d = ST_INVALIDATE;
        else if (fetch_i)   state_d = ST_COMPARE;
        else                state_d = ST_IDLE;
      end
      ST_REQUEST:  if (mem_ack_i) state_d = ST_FILL;
      ST_FILL:     if (mem_valid_i && last_beat) state_d = ST_VALIDATE;
      ST_VALIDATE: state_d = flush_any ? ST_INVALIDATE : ST_IDLE;
      default:     state_d = ST_INVALIDATE;
    endcase
  end

  // Stall is the only combinational output: a miss must hold fetch in the same cycle
  always_comb begin
    unique case (state_q)
      ST_IDLE:    stall_o = 1'b0;
      ST_COMPARE: stall_o = !hit_i || flush_any;
      default:    stall_o = 1'b1;
    endcase
  end

  // Index and beat counters, pending flush, captured fetch address
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      index_q         <= '0;
      beat_q          <= '0;
      flush_pending_q <= 1'b0;
      fetch_addr_q    <= '0;
    end else begin
      if (state_d == ST_INVALIDATE && (state_q != ST_INVALIDATE || flush_i))
        index_q <= '0;
      else if (state_q == ST_INVALIDATE)
        index_q <= index_q + INDEX'(1);

      if (state_q == ST_REQUEST && mem_ack_i)
        beat_q <= '0;
      else if (state_q == ST_FILL && mem_valid_i)
        beat_q <= beat_q + OFFSET'(1);

      if (state_d == ST_INVALIDATE) flush_pending_q <= 1'b0;
      else if (flush_i)             flush_pending_q <= 1'b1;

      if (state_d == ST_COMPARE) fetch_addr_q <= cache_address_t'(fetch_address_i);
    end
  end

  // Output decode; the write port reflects this cycle's action and appears on the next cycle
  always_comb begin
    fill_done_d     = 1'b0;
    mem_request_d   = (state_d == ST_REQUEST);
    mem_address_d   = (state_d == ST_REQUEST) ? 32'(base) : 32'd0;
    write_address_d = '0;
    write_d         = '0;
    instruction_d   = '0;
    valid_d         = 1'b0;
    unique case (state_q)
      ST_INVALIDATE: begin
        write_d.valid   = 1'b1;
        write_address_d = {{(32-INDEX-OFFSET-2){1'b0}}, index_q, {(OFFSET+2){1'b0}}};
      end
      ST_COMPARE: begin
        // Drop the valid bit before any beat lands so a partial block never hits
        if (!hit_i) begin
          write_d.valid   = 1'b1;
          write_address_d = 32'(base);
        end
      end
      ST_FILL: begin
        if (mem_valid_i) begin
          write_d.data    = 1'b1;
          instruction_d   = mem_data_i;
          write_address_d = 32'(beat_addr);
        end
      end
      ST_VALIDATE: begin
        write_d.tag     = 1'b1;
        write_d.valid   = 1'b1;
        valid_d         = 1'b1;
        write_address_d = 32'(base);
        fill_done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fill_done_o     <= 1'b0;
      mem_request_o   <= 1'b0;
      mem_address_o   <= '0;
      write_address_o <= '0;
      write_o         <= '0;
      instruction_o   <= '0;
      valid_o         <= 1'b0;
    end else begin
      fill_done_o     <= fill_done_d;
      mem_request_o   <= mem_request_d;
      mem_address_o   <= mem_address_d;
      write_address_o <= write_address_d;
      write_o         <= write_d;
      instruction_o   <= instruction_d;
      valid_o         <= valid_d;
    end
  end

endmodule

// File: tb/tb_instruction_cache_fill.sv
// Bench for instruction_cache_fill: directed scenarios plus random misses.
// A shadow cache image is built from the write port and compared with an expected image.
// Memory side is modelled directly by the stimulus steps.
module tb_instruction_cache_fill;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        fetch_i;
  logic [31:0] fetch_address_i;
  logic        hit_i;
  logic        flush_i;
  logic        stall_o;
  logic        fill_done_o;
  logic        mem_request_o;
  logic [31:0] mem_address_o;
  logic        mem_ack_i;
  logic        mem_valid_i;
  logic [31:0] mem_data_i;
  logic [31:0] write_address_o;
  logic [2:0]  write_o;
  logic [31:0] instruction_o;
  logic        valid_o;

  int checks = 0;
  int errors = 0;

  // Shadow of what the cache arrays would hold, built from the write port
  bit          sh_valid [512] = '{default: 1'b1};
  logic [31:0] sh_data  [2048] = '{default: 32'd0};
  logic [31:0] sh_tag   [512] = '{default: 32'd0};
  int          dcount = 0;
  logic [31:0] clr_log [$];

  // Expected cache image from the behavioural rules
  bit          exp_valid [512];
  logic [31:0] exp_data  [2048];
  logic [31:0] exp_tag   [512];

  instruction_cache_fill dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .fetch_i         (fetch_i),
    .fetch_address_i (fetch_address_i),
    .hit_i           (hit_i),
    .flush_i         (flush_i),
    .stall_o         (stall_o),
    .fill_done_o     (fill_done_o),
    .mem_request_o   (mem_request_o),
    .mem_address_o   (mem_address_o),
    .mem_ack_i       (mem_ack_i),
    .mem_valid_i     (mem_valid_i),
    .mem_data_i      (mem_data_i),
    .write_address_o (write_address_o),
    .write_o         (write_o),
    .instruction_o   (instruction_o),
    .valid_o         (valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Cache arrays latch the write port at the edge; sampled mid-cycle here
  always @(negedge clk_i) begin
    if (write_o[1]) begin
      sh_valid[int'((write_address_o >> 4) & 32'd511)] = valid_o;
      if (!valid_o) clr_log.push_back(write_address_o);
    end
    if (write_o[2]) begin
      sh_data[int'((write_address_o >> 2) & 32'd2047)] = instruction_o;
      dcount++;
    end
    if (write_o[0]) sh_tag[int'((write_address_o >> 4) & 32'd511)] = write_address_o >> 13;
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_invalidate();
    for (int i = 0; i < 512; i++) exp_valid[i] = 1'b0;
  endtask

  // Counts cycles from now until stall_o drops, bounded
  task automatic wait_idle(output int n);
    n = 0;
    while (stall_o && n < 600) begin
      step();
      n++;
    end
  endtask

  // One full miss from IDLE; returns at the cycle showing fill_done_o
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] words [4],
                         input int ack_wait, input int gap_max, input int flush_beat,
                         input bit junk);
    logic [31:0] base;
    int          d0;
    base = addr & ~32'hF;
    fetch_i = 1'b1; fetch_address_i = addr;
    step();
    fetch_i = 1'b0; hit_i = 1'b0;
    #1;
    check("miss_stall", {31'd0, stall_o}, 32'd1);
    step();
    check("req_asserted", {31'd0, mem_request_o}, 32'd1);
    check("req_address", mem_address_o, base);
    check("req_valid_clear", {28'd0, write_o, valid_o}, 32'b0100);
    check("req_clear_addr", write_address_o, base);
    d0 = dcount;
    for (int i = 0; i < ack_wait; i++) begin
      mem_valid_i = junk; mem_data_i = $urandom;
      step();
      check("req_held", {31'd0, mem_request_o}, 32'd1);
      check("req_addr_stable", mem_address_o, base);
      check("req_no_data", dcount, d0);
    end
    mem_valid_i = 1'b0;
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    check("req_dropped", {31'd0, mem_request_o}, 32'd0);
    for (int b = 0; b < 4; b++) begin
      repeat ($urandom_range(0, gap_max)) step();
      mem_valid_i = 1'b1; mem_data_i = words[b]; flush_i = (b == flush_beat);
      step();
      mem_valid_i = 1'b0; flush_i = 1'b0;
      check("beat_write", {28'd0, write_o, valid_o}, 32'b1000);
      check("beat_addr", write_address_o, base + 32'(4 * b));
      check("beat_data", instruction_o, words[b]);
    end
    step();
    check("fill_done", {31'd0, fill_done_o}, 32'd1);
    check("validate_write", {28'd0, write_o, valid_o}, 32'b0111);
    check("validate_addr", write_address_o, base);
    for (int b = 0; b < 4; b++) exp_data[int'((base >> 2) & 32'd2047) + b] = words[b];
    exp_valid[int'((base >> 4) & 32'd511)] = 1'b1;
    exp_tag[int'((base >> 4) & 32'd511)]   = base >> 13;
    @(negedge clk_i); #1;
  endtask

  initial begin
    logic [31:0] w [4];
    logic [31:0] a;
    int          n, d0, c0, bad;

    rst_n_i = 1'b0; fetch_i = 1'b0; fetch_address_i = '0; hit_i = 1'b0; flush_i = 1'b0;
    mem_ack_i = 1'b0; mem_valid_i = 1'b0; mem_data_i = '0;
    for (int i = 0; i < 2048; i++) exp_data[i] = '0;
    for (int i = 0; i < 512; i++) exp_tag[i] = '0;

    // 1: reset state and power-up invalidation
    #1;
    check("rst_stall", {31'd0, stall_o}, 32'd1);
    check("rst_outputs", {28'd0, write_o, valid_o}, 32'd0);
    check("rst_req", {30'd0, mem_request_o, fill_done_o}, 32'd0);
    check("rst_addr", write_address_o | mem_address_o | instruction_o, 32'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    c0 = clr_log.size();
    wait_idle(n);
    model_invalidate();
    check("init_cycles", n, 512);
    step();
    check("init_clears", clr_log.size() - c0, 512);
    check("init_first_addr", clr_log[c0], 32'h0000_0000);
    check("init_last_addr", clr_log[$], 32'h0000_1FF0);
    bad = 0;
    for (int i = 0; i < 512; i++) if (sh_valid[i] !== exp_valid[i]) bad++;
    check("init_all_invalid", bad, 0);

    // 2: directed miss at 0x1234
    w = '{32'hA, 32'hB, 32'hC, 32'hD};
    do_miss(32'h0000_1234, w, 0, 0, -1, 1'b0);
    step();
    check("fill_done_pulse", {31'd0, fill_done_o}, 32'd0);
    check("miss_data", {sh_data[32'h1230 >> 2], sh_data[32'h1234 >> 2]}, {32'hA, 32'hB}[31:0] | 32'd0);
    check("miss_data_hi", sh_data[32'h123C >> 2], 32'hD);
    check("miss_valid", {31'd0, sh_valid[32'h123]}, 32'd1);
    check("miss_tag", sh_tag[32'h123], 32'h0);

    // 3: back-to-back hits never stall nor touch memory
    d0 = dcount;
    fetch_i = 1'b1; fetch_address_i = $urandom;
    step();
    for (int k = 0; k < 5; k++) begin
      hit_i = 1'b1; fetch_i = 1'b1; fetch_address_i = $urandom;
      #1;
      check("hit_stall", {31'd0, stall_o}, 32'd0);
      step();
      check("hit_no_req", {31'd0, mem_request_o}, 32'd0);
    end
    fetch_i = 1'b0;
    step();
    hit_i = 1'b0;
    check("hit_idle_stall", {31'd0, stall_o}, 32'd0);
    check("hit_no_data", dcount, d0);

    // 4: flush during beat 2 completes the fill, then invalidates everything
    for (int b = 0; b < 4; b++) w[b] = $urandom;
    c0 = clr_log.size();
    do_miss(32'h0000_2A58, w, 1, 1, 2, 1'b0);
    model_invalidate();
    wait_idle(n);
    check("flush_inv_cycles", n, 512);
    step();
    check("flush_clears", clr_log.size() - c0, 513);
    check("flush_data_kept", sh_data[32'h2A58 >> 2], w[2]);
    bad = 0;
    for (int i = 0; i < 512; i++) if (sh_valid[i] !== exp_valid[i]) bad++;
    check("flush_all_invalid", bad, 0);

    // 5: reset after beat 1 aborts the fill
    a = 32'h0000_0F40;
    fetch_i = 1'b1; fetch_address_i = a;
    step();
    fetch_i = 1'b0; hit_i = 1'b0;
    step();
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    mem_valid_i = 1'b1; mem_data_i = 32'h1111_0000;
    step();
    mem_data_i = 32'h2222_0000;
    step();
    mem_valid_i = 1'b0;
    exp_data[int'(a >> 2)] = 32'h1111_0000;
    #2;
    rst_n_i = 1'b0;
    #1;
    check("arst_write", {28'd0, write_o, valid_o}, 32'd0);
    check("arst_req", {29'd0, mem_request_o, fill_done_o, stall_o}, 32'd1);
    check("arst_data", instruction_o | write_address_o, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    model_invalidate();
    d0 = dcount;
    mem_valid_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
    wait_idle(n);
    mem_valid_i = 1'b0;
    check("arst_inv_cycles", n, 512);
    check("arst_beats_ignored", dcount, d0);

    // 6: long ack wait with stray beats while requesting
    for (int b = 0; b < 4; b++) w[b] = $urandom;
    do_miss(32'h0000_7FF8, w, 10, 0, -1, 1'b1);

    // Random misses against the expected cache image
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 4; b++) w[b] = $urandom;
      do_miss($urandom, w, $urandom_range(0, 3), 2, -1, 1'b1);
    end
    step();
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      if (sh_valid[i] !== exp_valid[i]) bad++;
      if (exp_valid[i] && sh_tag[i] !== exp_tag[i]) bad++;
    end
    check("image_valid_tag", bad, 0);
    bad = 0;
    for (int i = 0; i < 2048; i++) if (sh_data[i] !== exp_data[i]) bad++;
    check("image_data", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
